// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit: FSM states,
// event priority encoding and the canned control-vector patterns.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_e;

    // Lower encoding wins when several events are active together.
    typedef enum logic [2:0] {
        EV_MEM_WAIT = 3'd0,
        EV_EX_BUSY  = 3'd1,
        EV_BRANCH   = 3'd2,
        EV_STALL    = 3'd3,
        EV_NONE     = 3'd4
    } ctrl_event_e;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{pc_we: 1'b1, if_id_we: 1'b1, id_ex_we: 1'b1,
                                       ex_mem_we: 1'b1, mem_wb_we: 1'b1,
                                       if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                       ex_mem_flush: 1'b0, mem_wb_flush: 1'b0};

    localparam ctrl_t CTRL_RESET   = '{pc_we: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0,
                                       ex_mem_we: 1'b0, mem_wb_we: 1'b0,
                                       if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                       ex_mem_flush: 1'b1, mem_wb_flush: 1'b1};

    localparam ctrl_t CTRL_HALTED  = '{pc_we: 1'b0, if_id_we: 1'b0, id_ex_we: 1'b0,
                                       ex_mem_we: 1'b0, mem_wb_we: 1'b0,
                                       if_id_flush: 1'b0, id_ex_flush: 1'b0,
                                       ex_mem_flush: 1'b0, mem_wb_flush: 1'b0};

    function automatic ctrl_event_e pick_event(input logic mem_wait,
                                               input logic ex_busy,
                                               input logic branch_taken,
                                               input logic hdu_stall);
        ctrl_event_e ev;
        ev = EV_NONE;
        if (mem_wait)          ev = EV_MEM_WAIT;
        else if (ex_busy)      ev = EV_EX_BUSY;
        else if (branch_taken) ev = EV_BRANCH;
        else if (hdu_stall)    ev = EV_STALL;
        return ev;
    endfunction

endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (inc && (value_q != {W{1'b1}})) begin
            value_d = value_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline write-enable / flush arbiter for the 5-stage core, with halt/drain
// sequencing and saturating stall/flush performance counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | normal issue; events arbitrated by priority
// ST_FLUSH  | IF/ID held flushed for FLUSH_DEPTH unmasked cycles
// ST_DRAIN  | fetch stopped, in-flight ID/EX/MEM retiring (DRAIN_CYCLES)
// ST_HALTED | all stages frozen until halt_req drops
module pipeline_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH  = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hdu_stall,
    input  logic             ex_branch_taken,
    input  logic             ex_busy,
    input  logic             mem_wait,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_DEPTH);
    localparam logic [2:0] DRAIN_LD = 3'(DRAIN_CYCLES);

    ctrl_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    ctrl_t       ctrl;
    ctrl_event_e ev;
    logic        masked;
    logic        redirect;
    logic        halted_d;
    logic        stall_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl     = CTRL_DEFAULT;
        halted_d = 1'b0;
        redirect = 1'b0;
        masked   = mem_wait | ex_busy;
        ev       = pick_event(mem_wait, ex_busy, ex_branch_taken, hdu_stall);

        if (state_q != ST_HALTED) begin
            case (ev)
                EV_MEM_WAIT: begin
                    ctrl.pc_we        = 1'b0;
                    ctrl.if_id_we     = 1'b0;
                    ctrl.id_ex_we     = 1'b0;
                    ctrl.ex_mem_we    = 1'b0;
                    ctrl.mem_wb_flush = 1'b1;
                end
                EV_EX_BUSY: begin
                    ctrl.pc_we        = 1'b0;
                    ctrl.if_id_we     = 1'b0;
                    ctrl.id_ex_we     = 1'b0;
                    ctrl.ex_mem_flush = 1'b1;
                end
                EV_BRANCH: begin
                    redirect         = 1'b1;
                    ctrl.pc_we       = 1'b1;
                    ctrl.if_id_flush = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                end
                EV_STALL: begin
                    ctrl.pc_we       = 1'b0;
                    ctrl.if_id_we    = 1'b0;
                    ctrl.id_ex_flush = 1'b1;
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_RUN: begin
                if (redirect && (FLUSH_LD != 3'd0)) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_LD;
                end
                if (halt_req) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LD;
                end
            end
            ST_FLUSH: begin
                ctrl.if_id_flush = 1'b1;
                if (redirect) begin
                    if (FLUSH_LD == 3'd0) state_d = ST_RUN;
                    cnt_d = FLUSH_LD;
                end else if (!masked) begin
                    if (cnt_q <= 3'd1) state_d = ST_RUN;
                    else               cnt_d = cnt_q - 3'd1;
                end
                if (halt_req) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LD;
                end
            end
            ST_DRAIN: begin
                // A late redirect still steers the PC but the drain keeps counting.
                ctrl.pc_we       = redirect;
                ctrl.if_id_flush = 1'b1;
                if (!masked) begin
                    if (cnt_q <= 3'd1) state_d = ST_HALTED;
                    else               cnt_d = cnt_q - 3'd1;
                end
            end
            ST_HALTED: begin
                ctrl     = CTRL_HALTED;
                halted_d = 1'b1;
                if (!halt_req) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase

        if (!rst_n) begin
            ctrl     = CTRL_RESET;
            halted_d = 1'b0;
        end
    end

    assign stall_inc = rst_n && (state_q != ST_HALTED) && !ctrl.pc_we;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .value (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect & rst_n),
        .value (flush_cnt)
    );

    assign pc_we        = ctrl.pc_we;
    assign if_id_we     = ctrl.if_id_we;
    assign id_ex_we     = ctrl.id_ex_we;
    assign ex_mem_we    = ctrl.ex_mem_we;
    assign mem_wb_we    = ctrl.mem_wb_we;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign halted       = halted_d;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: directed per-cycle vectors push
// hand-computed expectations; a negedge monitor pops and compares.
module tb_pipeline_control_unit;

    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    logic hdu_stall, ex_branch_taken, ex_busy, mem_wait, halt_req;
    logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    typedef struct {
        logic [8:0] ctrl;
        logic       halted;
        int         sc;
        int         fc;
        int         idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   vec_idx = 0;

    // {pc, if_id, id_ex, ex_mem, mem_wb}_we, {if_id, id_ex, ex_mem, mem_wb}_flush
    localparam logic [8:0] C_DEF  = 9'b11111_0000;
    localparam logic [8:0] C_RST  = 9'b00000_1111;
    localparam logic [8:0] C_HLT  = 9'b00000_0000;
    localparam logic [8:0] C_STL  = 9'b00111_0100;
    localparam logic [8:0] C_BR   = 9'b11111_1100;
    localparam logic [8:0] C_FL   = 9'b11111_1000;
    localparam logic [8:0] C_MW   = 9'b00001_0001;
    localparam logic [8:0] C_MWF  = 9'b00001_1001;
    localparam logic [8:0] C_BSY  = 9'b00011_0010;
    localparam logic [8:0] C_DRN  = 9'b01111_1000;

    pipeline_control_unit #(
        .FLUSH_DEPTH  (1),
        .DRAIN_CYCLES (3),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hdu_stall       (hdu_stall),
        .ex_branch_taken (ex_branch_taken),
        .ex_busy         (ex_busy),
        .mem_wait        (mem_wait),
        .halt_req        (halt_req),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .id_ex_we        (id_ex_we),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_we       (mem_wb_we),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_flush    (ex_mem_flush),
        .mem_wb_flush    (mem_wb_flush),
        .halted          (halted),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: r=rst_n, h=hdu_stall, b=branch, x=ex_busy, m=mem_wait, q=halt_req
    task automatic step(input logic r, input logic h, input logic b, input logic x,
                        input logic m, input logic q, input logic [8:0] e,
                        input logic eh, input int sc, input int fc);
        exp_t ex;
        @(posedge clk);
        #1;
        rst_n = r; hdu_stall = h; ex_branch_taken = b;
        ex_busy = x; mem_wait = m; halt_req = q;
        ex.ctrl = e; ex.halted = eh; ex.sc = sc; ex.fc = fc; ex.idx = vec_idx;
        vec_idx++;
        sb.push_back(ex);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t ex;
            logic [8:0] act;
            ex = sb.pop_front();
            act = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
            checks += 4;
            if (act !== ex.ctrl) begin
                failures++;
                $display("FAIL ctrl vec=%0d actual=%b required=%b", ex.idx, act, ex.ctrl);
            end
            if (halted !== ex.halted) begin
                failures++;
                $display("FAIL halted vec=%0d actual=%b required=%b", ex.idx, halted, ex.halted);
            end
            if (stall_cnt !== CNT_W'(ex.sc)) begin
                failures++;
                $display("FAIL stall_cnt vec=%0d actual=%0d required=%0d", ex.idx, stall_cnt, ex.sc);
            end
            if (flush_cnt !== CNT_W'(ex.fc)) begin
                failures++;
                $display("FAIL flush_cnt vec=%0d actual=%0d required=%0d", ex.idx, flush_cnt, ex.fc);
            end
        end
    end

    initial begin
        rst_n = 1'b0; hdu_stall = 1'b0; ex_branch_taken = 1'b0;
        ex_busy = 1'b0; mem_wait = 1'b0; halt_req = 1'b0;

        // reset held
        step(0,0,0,0,0,0, C_RST, 0, 0, 0);
        step(0,1,1,0,1,1, C_RST, 0, 0, 0);
        // single load-use stall
        step(1,0,0,0,0,0, C_DEF, 0, 0, 0);
        step(1,1,0,0,0,0, C_STL, 0, 0, 0);
        step(1,0,0,0,0,0, C_DEF, 0, 1, 0);
        // redirect with FLUSH_DEPTH=1
        step(1,0,1,0,0,0, C_BR,  0, 1, 0);
        step(1,0,0,0,0,0, C_FL,  0, 1, 1);
        step(1,0,0,0,0,0, C_DEF, 0, 1, 1);
        // branch+stall masked by mem_wait for two cycles
        step(1,1,1,0,1,0, C_MW,  0, 1, 1);
        step(1,1,1,0,1,0, C_MW,  0, 2, 1);
        step(1,1,1,0,0,0, C_BR,  0, 3, 1);
        step(1,0,0,0,0,0, C_FL,  0, 3, 2);
        step(1,0,0,0,0,0, C_DEF, 0, 3, 2);
        // ex_busy beats hdu_stall
        step(1,0,0,1,0,0, C_BSY, 0, 3, 2);
        step(1,1,0,1,0,0, C_BSY, 0, 4, 2);
        step(1,0,0,0,0,0, C_DEF, 0, 5, 2);
        // halt with a mem_wait pulse in the second drain cycle
        step(1,0,0,0,0,1, C_DEF, 0, 5, 2);
        step(1,0,0,0,0,1, C_DRN, 0, 5, 2);
        step(1,0,0,0,1,1, C_MWF, 0, 6, 2);
        step(1,0,0,0,0,1, C_DRN, 0, 7, 2);
        step(1,0,0,0,0,1, C_DRN, 0, 8, 2);
        step(1,0,0,0,0,1, C_HLT, 1, 9, 2);
        step(1,1,1,1,1,1, C_HLT, 1, 9, 2);
        step(1,0,0,0,0,0, C_HLT, 1, 9, 2);
        step(1,0,0,0,0,0, C_DEF, 0, 9, 2);
        // redirect during drain, halt_req dropped mid-drain
        step(1,0,0,0,0,1, C_DEF, 0, 9, 2);
        step(1,0,1,0,0,1, C_BR,  0, 9, 2);
        step(1,0,0,0,0,0, C_DRN, 0, 9, 3);
        step(1,0,0,0,0,0, C_DRN, 0, 10, 3);
        step(1,0,0,0,0,0, C_HLT, 1, 11, 3);
        step(1,0,0,0,0,0, C_DEF, 0, 11, 3);
        // reset asserted mid-FLUSH
        step(1,0,1,0,0,0, C_BR,  0, 11, 3);
        step(0,0,0,0,0,0, C_RST, 0, 0, 0);
        step(1,0,0,0,0,0, C_DEF, 0, 0, 0);
        // masked cycle inside FLUSH, then a reload redirect
        step(1,0,1,0,0,0, C_BR,  0, 0, 0);
        step(1,0,0,0,1,0, C_MWF, 0, 0, 1);
        step(1,0,1,0,0,0, C_BR,  0, 1, 1);
        step(1,0,0,0,0,0, C_FL,  0, 1, 2);
        step(1,0,0,0,0,0, C_DEF, 0, 1, 2);
        // stall counter saturation
        for (int k = 0; k < 20; k++) begin
            step(1,1,0,0,0,0, C_STL, 0, (1 + k > 15) ? 15 : 1 + k, 2);
        end
        step(1,0,0,0,0,0, C_DEF, 0, 15, 2);

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain_scoreboard pending=%0d required=0", sb.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
